// File: rtl/tqvp_counter_bank_pkg.sv
// Shared constants and helpers for the TinyQV counter-bank peripheral.
package tqvp_counter_bank_pkg;

    localparam logic [5:0] ADDR_CTRL       = 6'h00;
    localparam logic [5:0] ADDR_IRQ_STATUS = 6'h04;
    localparam logic [5:0] ADDR_IRQ_ENABLE = 6'h08;
    localparam logic [5:0] ADDR_UI         = 6'h0C;
    localparam logic [5:0] CH_BASE         = 6'h10;
    localparam logic [5:0] CH_STRIDE       = 6'h08;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_NONE = 2'b11;

    // Bits of data_in that a write of the given size is allowed to touch.
    function automatic logic [31:0] lane_mask(input logic [1:0] sz);
        case (sz)
            SZ_BYTE: lane_mask = 32'h0000_00FF;
            SZ_HALF: lane_mask = 32'h0000_FFFF;
            SZ_WORD: lane_mask = 32'hFFFF_FFFF;
            default: lane_mask = 32'h0000_0000;
        endcase
    endfunction

endpackage

// File: rtl/tqvp_counter_chan.sv
// One match-counter channel: COUNT, COMPARE, toggle output and match detection.
module tqvp_counter_chan
    import tqvp_counter_bank_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             oneshot,
    input  logic             count_we,
    input  logic             compare_we,
    input  logic [WIDTH-1:0] wdata,
    input  logic [WIDTH-1:0] mask,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] compare,
    output logic             toggle,
    output logic             match_c,
    output logic             oneshot_clear_c
);

    assign match_c         = en && (count == compare);
    assign oneshot_clear_c = match_c && oneshot;

    // A software write to COUNT takes priority over reload and increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            compare <= '0;
            toggle  <= 1'b0;
        end else begin
            if (count_we) begin
                count <= (count & ~mask) | (wdata & mask);
            end else if (match_c) begin
                count <= '0;
            end else if (en) begin
                count <= count + WIDTH'(1);
            end
            if (compare_we) begin
                compare <= (compare & ~mask) | (wdata & mask);
            end
            if (match_c) begin
                toggle <= ~toggle;
            end
        end
    end

endmodule

// File: rtl/tqvp_counter_bank.sv
// TinyQV peripheral: NUM_CH match counters with toggle outputs, sticky IRQs and a
// read port with programmable latency.
module tqvp_counter_bank
    import tqvp_counter_bank_pkg::*;
#(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned READ_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  ui_in,
    output logic [7:0]  uo_out,
    input  logic [5:0]  address,
    input  logic [31:0] data_in,
    input  logic [1:0]  data_write_n,
    input  logic [1:0]  data_read_n,
    output logic [31:0] data_out,
    output logic        data_ready,
    output logic        user_interrupt
);

    logic [5:0]        word_addr;
    logic [31:0]       wmask;
    logic              write_en;
    logic              read_req;
    logic              ctrl_we;
    logic              status_we;
    logic              ienable_we;
    logic [NUM_CH-1:0] en_q;
    logic [NUM_CH-1:0] oneshot_q;
    logic [NUM_CH-1:0] irq_status;
    logic [NUM_CH-1:0] irq_enable;
    logic [NUM_CH-1:0] match;
    logic [NUM_CH-1:0] oneshot_clear;
    logic [NUM_CH-1:0] toggle;
    logic [WIDTH-1:0]  chan_count   [NUM_CH];
    logic [WIDTH-1:0]  chan_compare [NUM_CH];
    logic [31:0]       rdata;
    logic              unused_bits;

    assign word_addr  = {address[5:2], 2'b00};
    assign wmask      = lane_mask(data_write_n);
    assign write_en   = data_write_n != SZ_NONE;
    assign read_req   = data_read_n != SZ_NONE;
    assign ctrl_we    = write_en && (word_addr == ADDR_CTRL);
    assign status_we  = write_en && (word_addr == ADDR_IRQ_STATUS);
    assign ienable_we = write_en && (word_addr == ADDR_IRQ_ENABLE);
    assign uo_out     = 8'(toggle);
    assign unused_bits = ^{address[1:0], data_in, wmask};

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        localparam logic [5:0] CNT_ADDR = 6'(CH_BASE + CH_STRIDE * c);
        tqvp_counter_chan #(.WIDTH(WIDTH)) u_chan (
            .clk             (clk),
            .rst             (rst),
            .en              (en_q[c]),
            .oneshot         (oneshot_q[c]),
            .count_we        (write_en && (word_addr == CNT_ADDR)),
            .compare_we      (write_en && (word_addr == CNT_ADDR + 6'h04)),
            .wdata           (data_in[WIDTH-1:0]),
            .mask            (wmask[WIDTH-1:0]),
            .count           (chan_count[c]),
            .compare         (chan_compare[c]),
            .toggle          (toggle[c]),
            .match_c         (match[c]),
            .oneshot_clear_c (oneshot_clear[c])
        );
    end

    // Control and interrupt registers; CTRL writes beat one-shot clears, matches beat W1C.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q           <= '0;
            oneshot_q      <= '0;
            irq_status     <= '0;
            irq_enable     <= '0;
            user_interrupt <= 1'b0;
        end else begin
            if (ctrl_we) begin
                en_q      <= (en_q & ~wmask[NUM_CH-1:0]) | (data_in[NUM_CH-1:0] & wmask[NUM_CH-1:0]);
                oneshot_q <= (oneshot_q & ~wmask[8 +: NUM_CH])
                           | (data_in[8 +: NUM_CH] & wmask[8 +: NUM_CH]);
            end else begin
                en_q <= en_q & ~oneshot_clear;
            end
            if (status_we) begin
                irq_status <= (irq_status & ~(data_in[NUM_CH-1:0] & wmask[NUM_CH-1:0])) | match;
            end else begin
                irq_status <= irq_status | match;
            end
            if (ienable_we) begin
                irq_enable <= (irq_enable & ~wmask[NUM_CH-1:0])
                            | (data_in[NUM_CH-1:0] & wmask[NUM_CH-1:0]);
            end
            user_interrupt <= |(irq_status & irq_enable);
        end
    end

    if (READ_LAT == 0) begin : g_lat0
        assign data_ready = read_req;
    end else begin : g_lat
        localparam logic [1:0] LAT_LAST = 2'(READ_LAT - 1);
        logic [1:0] lat_cnt;
        logic       ready_q;

        // Latency restarts whenever the request is withdrawn or reset hits.
        always_ff @(posedge clk) begin
            if (rst || !read_req) begin
                lat_cnt <= '0;
                ready_q <= 1'b0;
            end else if (!ready_q) begin
                lat_cnt <= lat_cnt + 2'd1;
                ready_q <= lat_cnt == LAT_LAST;
            end
        end

        assign data_ready = ready_q;
    end

    always_comb begin
        rdata = '0;
        case (word_addr)
            ADDR_CTRL:       rdata = 32'({oneshot_q, 8'(en_q)});
            ADDR_IRQ_STATUS: rdata = 32'(irq_status);
            ADDR_IRQ_ENABLE: rdata = 32'(irq_enable);
            ADDR_UI:         rdata = 32'(ui_in);
            default: begin
                for (int unsigned c = 0; c < NUM_CH; c++) begin
                    if (word_addr == 6'(CH_BASE + CH_STRIDE * c)) begin
                        rdata = 32'(chan_count[c]);
                    end
                    if (word_addr == 6'(CH_BASE + CH_STRIDE * c + 6'h04)) begin
                        rdata = 32'(chan_compare[c]);
                    end
                end
            end
        endcase
    end

    assign data_out = data_ready ? rdata : 32'h0;

endmodule

// File: tb/tb_tqvp_counter_bank.sv
// Scoreboard bench for tqvp_counter_bank: register-file reference model plus a
// small second instance for narrow-width and long-latency behaviour.
`timescale 1ns/1ps
module tb_tqvp_counter_bank;

    localparam int unsigned NCH = 4;
    localparam int unsigned LAT = 1;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [7:0]  ui_in;
    logic [7:0]  uo_out;
    logic [5:0]  address;
    logic [31:0] data_in;
    logic [1:0]  data_write_n;
    logic [1:0]  data_read_n;
    logic [31:0] data_out;
    logic        data_ready;
    logic        user_interrupt;

    logic        rst2;
    logic [7:0]  ui_in2;
    logic [7:0]  uo_out2;
    logic [5:0]  address2;
    logic [31:0] data_in2;
    logic [1:0]  dwn2;
    logic [1:0]  drn2;
    logic [31:0] data_out2;
    logic        data_ready2;
    logic        user_interrupt2;

    tqvp_counter_bank #(.NUM_CH(NCH), .WIDTH(32), .READ_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .ui_in(ui_in), .uo_out(uo_out), .address(address),
        .data_in(data_in), .data_write_n(data_write_n), .data_read_n(data_read_n),
        .data_out(data_out), .data_ready(data_ready), .user_interrupt(user_interrupt)
    );

    tqvp_counter_bank #(.NUM_CH(2), .WIDTH(16), .READ_LAT(3)) dut2 (
        .clk(clk), .rst(rst2), .ui_in(ui_in2), .uo_out(uo_out2), .address(address2),
        .data_in(data_in2), .data_write_n(dwn2), .data_read_n(drn2),
        .data_out(data_out2), .data_ready(data_ready2), .user_interrupt(user_interrupt2)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole register file of the main instance as the software sees it.
    typedef struct packed {
        logic [NCH-1:0][31:0] cnt;
        logic [NCH-1:0][31:0] cmp;
        logic [NCH-1:0]       en;
        logic [NCH-1:0]       os;
        logic [NCH-1:0]       st;
        logic [NCH-1:0]       ie;
        logic [NCH-1:0]       tog;
        logic                 irq;
    } model_t;

    model_t m;

    function automatic logic [31:0] size_bits(input logic [1:0] sz);
        case (sz)
            2'b00:   return 32'h0000_00FF;
            2'b01:   return 32'h0000_FFFF;
            2'b10:   return 32'hFFFF_FFFF;
            default: return 32'h0;
        endcase
    endfunction

    function automatic model_t m_next(input model_t s, input logic [5:0] a,
                                      input logic [31:0] d, input logic [1:0] wn);
        model_t         n = s;
        logic [31:0]    k = size_bits(wn);
        int unsigned    w = int'(a[5:2]);
        logic [NCH-1:0] hit;
        logic [31:0]    ctrl;
        n.irq = |(s.st & s.ie);
        for (int c = 0; c < NCH; c++) begin
            hit[c] = s.en[c] && (s.cnt[c] == s.cmp[c]);
            if (hit[c]) n.tog[c] = ~s.tog[c];
            if (k != 0 && w == 4 + 2 * c) n.cnt[c] = (s.cnt[c] & ~k) | (d & k);
            else if (hit[c])              n.cnt[c] = 32'h0;
            else if (s.en[c])             n.cnt[c] = s.cnt[c] + 32'd1;
            if (k != 0 && w == 5 + 2 * c) n.cmp[c] = (s.cmp[c] & ~k) | (d & k);
        end
        if (k != 0 && w == 0) begin
            ctrl = ((32'(s.os) << 8) | 32'(s.en)) & ~k | (d & k);
            n.en = ctrl[NCH-1:0];
            n.os = ctrl[8 +: NCH];
        end else begin
            n.en = s.en & ~(hit & s.os);
        end
        n.st = s.st | hit;
        if (k != 0 && w == 1) n.st = (s.st & ~(d[NCH-1:0] & k[NCH-1:0])) | hit;
        if (k != 0 && w == 2) n.ie = (s.ie & ~k[NCH-1:0]) | (d[NCH-1:0] & k[NCH-1:0]);
        return n;
    endfunction

    function automatic logic [31:0] m_read(input model_t s, input logic [5:0] a, input logic [7:0] ui);
        int unsigned w = int'(a[5:2]);
        if (w == 0) return (32'(s.os) << 8) | 32'(s.en);
        if (w == 1) return 32'(s.st);
        if (w == 2) return 32'(s.ie);
        if (w == 3) return 32'(ui);
        if ((w - 4) / 2 < NCH) return ((w % 2) == 0) ? s.cnt[(w - 4) / 2] : s.cmp[(w - 4) / 2];
        return 32'h0;
    endfunction

    always @(posedge clk) begin
        m <= rst ? '0 : m_next(m, address, data_in, data_write_n);
    end

    // Monitor: pins every cycle, read data whenever data_ready rises.
    logic [31:0] exp_q[$];
    logic        mon_on = 1'b0;
    logic        prev_ready = 1'b0;
    int          wait_cyc = 0;

    always @(negedge clk) begin
        if (mon_on) begin
            check("uo_out", 32'(uo_out), 32'(m.tog));
            check("user_interrupt", 32'(user_interrupt), 32'(m.irq));
            if (data_read_n != 2'b11) begin
                if (data_ready && !prev_ready) begin
                    check("read_latency", 32'(wait_cyc), 32'(LAT));
                    if (exp_q.size() == 0) check("read_unexpected", data_out, 32'hDEAD_BEEF);
                    else check("read_data", data_out, exp_q.pop_front());
                end else if (!data_ready) begin
                    wait_cyc <= wait_cyc + 1;
                    if (wait_cyc > 8) check("read_timeout", 32'(data_ready), 32'h1);
                end
            end else begin
                wait_cyc <= 0;
            end
        end
        prev_ready <= data_ready;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wr(input logic [5:0] a, input logic [1:0] sz, input logic [31:0] d);
        address = a; data_in = d; data_write_n = sz;
        @(posedge clk);
        #2 data_write_n = 2'b11;
    endtask

    task automatic rd(input logic [5:0] a, input logic [1:0] sz, input bit use_c, input logic [31:0] cval);
        address = a; data_read_n = sz;
        repeat (LAT) @(posedge clk);
        #1 exp_q.push_back(use_c ? cval : m_read(m, a, ui_in));
        @(posedge clk);
        #1 check("read_consumed", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        #1 data_read_n = 2'b11;
        @(posedge clk);
        #1 check("ready_release", 32'(data_ready), 32'h0);
        #1;
    endtask

    task automatic rd2(input logic [5:0] a, input logic [31:0] exp, input bit do_rst);
        int n = 0;
        address2 = a; drn2 = 2'b10;
        if (do_rst) begin
            repeat (2) @(posedge clk);
            #2 rst2 = 1'b1;
            @(posedge clk);
            #1 check("rst_abort_ready", 32'(data_ready2), 32'h0);
            #1 rst2 = 1'b0;
        end
        while (!data_ready2 && n < 10) begin
            @(posedge clk);
            #1 n++;
        end
        check("lat3_cycles", 32'(n), 32'd3);
        check("lat3_data", data_out2, exp);
        #1 drn2 = 2'b11;
        @(posedge clk);
        #1 check("lat3_release", 32'(data_ready2), 32'h0);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        logic [5:0]  a;
        logic [31:0] d;
        int          r;
        rst = 1'b1; rst2 = 1'b1;
        ui_in = 8'h00; address = 6'h00; data_in = 32'h0; data_write_n = 2'b11; data_read_n = 2'b11;
        ui_in2 = 8'h00; address2 = 6'h00; data_in2 = 32'h0; dwn2 = 2'b11; drn2 = 2'b11;
        @(posedge clk);
        #2 mon_on = 1'b1;
        idle(2);
        rst = 1'b0; rst2 = 1'b0;
        check("reset_uo_out2", 32'(uo_out2), 32'h0);

        // Reset state.
        rd(6'h00, 2'b10, 1, 32'h0);
        rd(6'h04, 2'b10, 1, 32'h0);
        rd(6'h10, 2'b10, 1, 32'h0);

        // Periodic channel 0 with interrupt, then W1C.
        wr(6'h14, 2'b10, 32'd3);
        wr(6'h08, 2'b10, 32'h1);
        wr(6'h00, 2'b10, 32'h1);
        idle(3);
        rd(6'h10, 2'b10, 0, 32'h0);
        idle(7);
        wr(6'h04, 2'b00, 32'h1);
        idle(6);

        // One-shot channel 1 (also stops channel 0).
        wr(6'h1C, 2'b10, 32'd5);
        wr(6'h00, 2'b01, 32'h0202);
        idle(10);
        rd(6'h00, 2'b10, 1, 32'h0000_0200);
        rd(6'h18, 2'b10, 1, 32'h0);

        // Byte and half writes on a disabled channel.
        wr(6'h20, 2'b10, 32'h1234_5678);
        wr(6'h20, 2'b00, 32'hFFFF_FFAB);
        rd(6'h20, 2'b10, 1, 32'h1234_56AB);
        wr(6'h20, 2'b01, 32'hFFFF_BEEF);
        rd(6'h20, 2'b10, 1, 32'h1234_BEEF);

        // W1C in the same cycle as a channel-0 match: status bit survives.
        wr(6'h04, 2'b10, 32'hF);
        wr(6'h10, 2'b10, 32'h0);
        wr(6'h00, 2'b10, 32'h1);
        for (int i = 0; i < 8 && m.cnt[0] != m.cmp[0]; i++) idle(1);
        wr(6'h04, 2'b00, 32'h1);
        rd(6'h04, 2'b10, 1, 32'h1);

        // COUNT write beats increment; one latency cycle of counting follows.
        wr(6'h10, 2'b10, 32'd7);
        rd(6'h10, 2'b10, 1, 32'd8);
        wr(6'h00, 2'b10, 32'h0);

        // Randomised traffic against the model.
        for (int i = 0; i < 250; i++) begin
            r = int'($urandom_range(0, 9));
            ui_in = 8'($urandom);
            a = 6'($urandom);
            d = $urandom;
            if (a >= 6'h10) d = $urandom_range(0, 12);
            if (r < 5)      wr(a, 2'($urandom_range(0, 2)), d);
            else if (r < 9) rd(a, 2'($urandom_range(0, 2)), 0, 32'h0);
            else            idle(int'($urandom_range(1, 5)));
        end
        idle(2);

        // Narrow width and three-cycle read latency on the second instance.
        address2 = 6'h10; data_in2 = 32'hFFFF_1234; dwn2 = 2'b10;
        @(posedge clk);
        #2 dwn2 = 2'b11;
        rd2(6'h10, 32'h0000_1234, 0);
        ui_in2 = 8'h5A;
        rd2(6'h0C, 32'h0000_005A, 0);
        rd2(6'h0C, 32'h0000_005A, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
